// File: rtl/modrm_sib_decode_if.sv
// Bundle between the ModR/M decoder, the prefetch FIFO, the register file and the sequencer.
// master: decoder side; slave: surrounding core (or testbench).
interface modrm_sib_decode_if #(
    parameter int unsigned EA_WIDTH = 32
);
    logic                start;
    logic                addr32;
    logic                busy;
    logic                complete;
    logic [EA_WIDTH-1:0] effective_address;
    logic [2:0]          regnum;
    logic                rm_is_reg;
    logic [2:0]          rm_regnum;
    logic                ss_default;
    logic [2:0]          reg_sel0;
    logic [2:0]          reg_sel1;
    logic [EA_WIDTH-1:0] reg_data0;
    logic [EA_WIDTH-1:0] reg_data1;
    logic                fifo_rd_en;
    logic [7:0]          fifo_rd_data;
    logic                fifo_empty;

    modport master (
        input  start, addr32, reg_data0, reg_data1, fifo_rd_data, fifo_empty,
        output busy, complete, effective_address, regnum, rm_is_reg, rm_regnum, ss_default,
               reg_sel0, reg_sel1, fifo_rd_en
    );

    modport slave (
        output start, addr32, reg_data0, reg_data1, fifo_rd_data, fifo_empty,
        input  busy, complete, effective_address, regnum, rm_is_reg, rm_regnum, ss_default,
               reg_sel0, reg_sel1, fifo_rd_en
    );
endinterface

// File: rtl/modrm_sib_decode.sv
// ModR/M decoder: pulls ModR/M, SIB and displacement bytes from the FIFO and registers the EA.
// Define SIB_EN to compile in 32-bit addressing (SIB byte, disp32); otherwise pure 16-bit decoder.
module modrm_sib_decode #(
    parameter int unsigned EA_WIDTH = 32
) (
    input logic                clk,
    input logic                reset_n,
    modrm_sib_decode_if.master bus
);

    localparam logic [2:0] RegSp = 3'd4;
    localparam logic [2:0] RegBx = 3'd3;
    localparam logic [2:0] RegBp = 3'd5;
    localparam logic [2:0] RegSi = 3'd6;
    localparam logic [2:0] RegDi = 3'd7;

`ifdef SIB_EN
    typedef enum logic [2:0] {StIdle, StModrm, StSib, StDisp, StEa, StDone} state_e;
`else
    typedef enum logic [2:0] {StIdle, StModrm, StDisp, StEa, StDone} state_e;
`endif

    state_e              state_q, state_d;
    logic [7:0]          modrm_q, modrm_d;
    logic [31:0]         disp_q, disp_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [2:0]          len_q, len_d;
    logic [EA_WIDTH-1:0] ea_q, ea_d;
    logic [2:0]          regnum_q, regnum_d;
    logic [2:0]          rm_regnum_q, rm_regnum_d;
    logic                rm_is_reg_q, rm_is_reg_d;
    logic                ss_q, ss_d;
    logic                complete_q, complete_d;
    logic                a32;

    logic [2:0]  sel0, sel1;
    logic        use0, use1;
    logic [1:0]  shamt;
    logic        ss_calc;
    logic [31:0] base_v, idx_v, disp_ext, sum, ea_calc;

    function automatic logic [2:0] disp_len16(input logic [1:0] md, input logic [2:0] rm);
        case (md)
            2'b01:   return 3'd1;
            2'b10:   return 3'd2;
            2'b00:   return (rm == 3'b110) ? 3'd2 : 3'd0;
            default: return 3'd0;
        endcase
    endfunction

`ifdef SIB_EN
    logic [7:0] sib_q, sib_d;
    logic       a32_q, a32_d;

    assign a32 = a32_q;

    // base only matters when a SIB byte is present (rm=100)
    function automatic logic [2:0] disp_len32(input logic [1:0] md, input logic [2:0] rm,
                                              input logic [2:0] base);
        case (md)
            2'b01:   return 3'd1;
            2'b10:   return 3'd4;
            2'b00:   return (rm == 3'b101 || (rm == 3'b100 && base == 3'b101)) ? 3'd4 : 3'd0;
            default: return 3'd0;
        endcase
    endfunction
`else
    assign a32 = 1'b0;
`endif

    // Register selects and address arithmetic from the latched bytes; meaningful in StEa.
    always_comb begin
        sel0  = 3'd0;
        sel1  = 3'd0;
        use0  = 1'b0;
        use1  = 1'b0;
        shamt = 2'd0;
`ifdef SIB_EN
        if (a32) begin
            if (modrm_q[2:0] == 3'b100) begin
                sel0  = sib_q[2:0];
                use0  = !(modrm_q[7:6] == 2'b00 && sib_q[2:0] == 3'b101);
                sel1  = sib_q[5:3];
                use1  = (sib_q[5:3] != 3'b100);
                shamt = sib_q[7:6];
            end else begin
                sel0 = modrm_q[2:0];
                use0 = !(modrm_q[7:6] == 2'b00 && modrm_q[2:0] == 3'b101);
            end
        end else
`endif
        begin
            case (modrm_q[2:0])
                3'b000:  begin sel0 = RegBx; use0 = 1'b1; sel1 = RegSi; use1 = 1'b1; end
                3'b001:  begin sel0 = RegBx; use0 = 1'b1; sel1 = RegDi; use1 = 1'b1; end
                3'b010:  begin sel0 = RegBp; use0 = 1'b1; sel1 = RegSi; use1 = 1'b1; end
                3'b011:  begin sel0 = RegBp; use0 = 1'b1; sel1 = RegDi; use1 = 1'b1; end
                3'b100:  begin sel0 = RegSi; use0 = 1'b1; end
                3'b101:  begin sel0 = RegDi; use0 = 1'b1; end
                3'b110:  begin sel0 = RegBp; use0 = (modrm_q[7:6] != 2'b00); end
                default: begin sel0 = RegBx; use0 = 1'b1; end
            endcase
        end

        ss_calc = use0 && (sel0 == RegBp || (a32 && sel0 == RegSp));
        base_v  = use0 ? 32'(bus.reg_data0) : 32'd0;
        idx_v   = use1 ? (32'(bus.reg_data1) << shamt) : 32'd0;
        case (len_q)
            3'd1:    disp_ext = {{24{disp_q[7]}}, disp_q[7:0]};
            3'd2:    disp_ext = {{16{disp_q[15]}}, disp_q[15:0]};
            3'd4:    disp_ext = disp_q;
            default: disp_ext = 32'd0;
        endcase
        sum     = base_v + idx_v + disp_ext;
        ea_calc = a32 ? sum : {16'd0, sum[15:0]};
    end

    always_comb begin
        state_d     = state_q;
        modrm_d     = modrm_q;
        disp_d      = disp_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        ea_d        = ea_q;
        regnum_d    = regnum_q;
        rm_regnum_d = rm_regnum_q;
        rm_is_reg_d = rm_is_reg_q;
        ss_d        = ss_q;
`ifdef SIB_EN
        sib_d       = sib_q;
        a32_d       = a32_q;
`endif
        case (state_q)
            // DONE also accepts start so back-to-back decodes need no idle cycle
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    modrm_d = 8'd0;
                    disp_d  = 32'd0;
                    cnt_d   = 3'd0;
                    len_d   = 3'd0;
`ifdef SIB_EN
                    sib_d   = 8'd0;
                    a32_d   = (EA_WIDTH == 32) && bus.addr32;
`endif
                    state_d = StModrm;
                end
            end
            StModrm: begin
                if (!bus.fifo_empty) begin
                    modrm_d = bus.fifo_rd_data;
`ifdef SIB_EN
                    len_d = a32 ? disp_len32(bus.fifo_rd_data[7:6], bus.fifo_rd_data[2:0], 3'd0)
                                : disp_len16(bus.fifo_rd_data[7:6], bus.fifo_rd_data[2:0]);
`else
                    len_d = disp_len16(bus.fifo_rd_data[7:6], bus.fifo_rd_data[2:0]);
`endif
                    if (bus.fifo_rd_data[7:6] == 2'b11) begin
                        ea_d        = '0;
                        regnum_d    = bus.fifo_rd_data[5:3];
                        rm_regnum_d = bus.fifo_rd_data[2:0];
                        rm_is_reg_d = 1'b1;
                        ss_d        = 1'b0;
                        state_d     = StDone;
                    end
`ifdef SIB_EN
                    else if (a32 && bus.fifo_rd_data[2:0] == 3'b100) begin
                        state_d = StSib;
                    end
`endif
                    else if (len_d != 3'd0) begin
                        state_d = StDisp;
                    end else begin
                        state_d = StEa;
                    end
                end
            end
`ifdef SIB_EN
            StSib: begin
                if (!bus.fifo_empty) begin
                    sib_d   = bus.fifo_rd_data;
                    len_d   = disp_len32(modrm_q[7:6], modrm_q[2:0], bus.fifo_rd_data[2:0]);
                    state_d = (len_d != 3'd0) ? StDisp : StEa;
                end
            end
`endif
            StDisp: begin
                if (!bus.fifo_empty) begin
                    disp_d[{cnt_q[1:0], 3'b000} +: 8] = bus.fifo_rd_data;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_d == len_q) begin
                        state_d = StEa;
                    end
                end
            end
            StEa: begin
                ea_d        = EA_WIDTH'(ea_calc);
                regnum_d    = modrm_q[5:3];
                rm_regnum_d = modrm_q[2:0];
                rm_is_reg_d = 1'b0;
                ss_d        = ss_calc;
                state_d     = StDone;
            end
            default: state_d = StIdle;
        endcase
        complete_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            modrm_q     <= 8'd0;
            disp_q      <= 32'd0;
            cnt_q       <= 3'd0;
            len_q       <= 3'd0;
            ea_q        <= '0;
            regnum_q    <= 3'd0;
            rm_regnum_q <= 3'd0;
            rm_is_reg_q <= 1'b0;
            ss_q        <= 1'b0;
            complete_q  <= 1'b0;
`ifdef SIB_EN
            sib_q       <= 8'd0;
            a32_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            modrm_q     <= modrm_d;
            disp_q      <= disp_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            ea_q        <= ea_d;
            regnum_q    <= regnum_d;
            rm_regnum_q <= rm_regnum_d;
            rm_is_reg_q <= rm_is_reg_d;
            ss_q        <= ss_d;
            complete_q  <= complete_d;
`ifdef SIB_EN
            sib_q       <= sib_d;
            a32_q       <= a32_d;
`endif
        end
    end

`ifdef SIB_EN
    assign bus.fifo_rd_en = !bus.fifo_empty &&
                            (state_q == StModrm || state_q == StSib || state_q == StDisp);
`else
    assign bus.fifo_rd_en = !bus.fifo_empty && (state_q == StModrm || state_q == StDisp);
`endif
    assign bus.busy              = bus.start | (state_q != StIdle);
    assign bus.complete          = complete_q;
    assign bus.effective_address = ea_q;
    assign bus.regnum            = regnum_q;
    assign bus.rm_regnum         = rm_regnum_q;
    assign bus.rm_is_reg         = rm_is_reg_q;
    assign bus.ss_default        = ss_q;
    assign bus.reg_sel0          = sel0;
    assign bus.reg_sel1          = sel1;

endmodule

// File: tb/tb_modrm_sib_decode.sv
// Directed bench for modrm_sib_decode: FIFO and register-file models, latency and result checks.
// 32-bit vectors run only when SIB_EN is defined; otherwise addr32 must be ignored.
module tb_modrm_sib_decode;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    modrm_sib_decode_if #(.EA_WIDTH(32)) bus ();

    modrm_sib_decode #(.EA_WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [16];
    logic [31:0] regs [8];
    int          wr_ptr    = 0;
    int          rd_ptr    = 0;
    int          pops      = 0;
    int          bad_pops  = 0;
    logic        stall     = 1'b0;
    logic        flush     = 1'b0;
    int          checks    = 0;
    int          errors    = 0;

    assign bus.fifo_empty   = stall || (rd_ptr == wr_ptr);
    assign bus.fifo_rd_data = mem[rd_ptr[3:0]];
    assign bus.reg_data0    = regs[bus.reg_sel0];
    assign bus.reg_data1    = regs[bus.reg_sel1];

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_rd_en) begin
            if (bus.fifo_empty) begin
                bad_pops <= bad_pops + 1;
            end else begin
                rd_ptr <= rd_ptr + 1;
                pops   <= pops + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[3:0]] = b;
        wr_ptr++;
    endtask

    // Starts a decode in the current cycle; returns cycles until complete (bounded).
    task automatic run(input logic a32, input int stall_n, output int lat);
        bus.addr32 = a32;
        bus.start  = 1'b1;
        stall      = (stall_n > 0);
        lat        = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            bus.start = 1'b0;
            if (lat > stall_n) stall = 1'b0;
        end while (!bus.complete && lat < 30);
    endtask

    initial begin
        int lat;
        int p0;
        bus.start  = 1'b0;
        bus.addr32 = 1'b0;
        for (int i = 0; i < 8; i++) regs[i] = 32'd0;
        regs[0] = 32'h0000_1000;
        regs[1] = 32'h0000_0010;
        regs[3] = 32'h0000_1000;
        regs[4] = 32'h0000_2000;
        regs[5] = 32'h0000_0100;
        regs[6] = 32'h0000_0234;
        regs[7] = 32'h0000_0020;

        push(8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_complete", bus.complete, 0);
        check("rst_rd_en", bus.fifo_rd_en, 0);
        check("rst_ea", bus.effective_address, 0);
        check("rst_fields", {bus.ss_default, bus.rm_is_reg, bus.regnum, bus.rm_regnum}, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_no_pop", pops, 0);
        check("idle_busy", bus.busy, 0);

        // [BX+SI]
        p0 = pops;
        run(1'b0, 0, lat);
        check("t1_lat", lat, 3);
        check("t1_ea", bus.effective_address, 32'h0000_1234);
        check("t1_ss", bus.ss_default, 0);
        check("t1_pops", pops - p0, 1);
        check("t1_fields", {bus.rm_is_reg, bus.regnum, bus.rm_regnum}, 7'h00);
        @(posedge clk);
        #1;
        check("t1_pulse", bus.complete, 0);
        check("t1_hold", bus.effective_address, 32'h0000_1234);

        // [BP-2]
        push(8'h46);
        push(8'hFE);
        p0 = pops;
        run(1'b0, 0, lat);
        check("t2_lat", lat, 4);
        check("t2_ea", bus.effective_address, 32'h0000_00FE);
        check("t2_ss", bus.ss_default, 1);
        check("t2_pops", pops - p0, 2);
        check("t2_fields", {bus.rm_is_reg, bus.regnum, bus.rm_regnum}, 7'h06);

        // register form, started back-to-back, FIFO empty for 3 cycles
        push(8'hC3);
        p0 = pops;
        run(1'b0, 3, lat);
        check("t3_lat", lat, 5);
        check("t3_fields", {bus.rm_is_reg, bus.regnum, bus.rm_regnum}, 7'h43);
        check("t3_ea", bus.effective_address, 0);
        check("t3_ss", bus.ss_default, 0);
        check("t3_pops", pops - p0, 1);
        check("t3_bad_pops", bad_pops, 0);

        // [BP+DI+disp16] with disp16=0xFFF0 wrapping
        push(8'h9B);
        push(8'hF0);
        push(8'hFF);
        p0 = pops;
        run(1'b0, 0, lat);
        check("t4_lat", lat, 5);
        check("t4_ea", bus.effective_address, 32'h0000_0110);
        check("t4_ss", bus.ss_default, 1);
        check("t4_fields", {bus.rm_is_reg, bus.regnum, bus.rm_regnum}, 7'h1B);
        check("t4_pops", pops - p0, 3);

        // disp16 only
        push(8'h06);
        push(8'h34);
        push(8'h12);
        run(1'b0, 0, lat);
        check("t5_lat", lat, 5);
        check("t5_ea", bus.effective_address, 32'h0000_1234);
        check("t5_ss", bus.ss_default, 0);

`ifdef SIB_EN
        // [EAX+ECX*4]
        push(8'h04);
        push(8'h88);
        p0 = pops;
        run(1'b1, 0, lat);
        check("s1_lat", lat, 4);
        check("s1_ea", bus.effective_address, 32'h0000_1040);
        check("s1_ss", bus.ss_default, 0);
        check("s1_pops", pops - p0, 2);

        // disp32 only
        push(8'h05);
        push(8'h78);
        push(8'h56);
        push(8'h34);
        push(8'h12);
        p0 = pops;
        run(1'b1, 0, lat);
        check("s2_lat", lat, 7);
        check("s2_ea", bus.effective_address, 32'h1234_5678);
        check("s2_ss", bus.ss_default, 0);
        check("s2_pops", pops - p0, 5);

        // [ESP] via SIB, no index
        push(8'h04);
        push(8'h24);
        run(1'b1, 0, lat);
        check("s3_lat", lat, 4);
        check("s3_ea", bus.effective_address, 32'h0000_2000);
        check("s3_ss", bus.ss_default, 1);
`else
        // addr32 ignored: 0x04 decodes as 16-bit [SI]
        push(8'h04);
        p0 = pops;
        run(1'b1, 0, lat);
        check("n1_lat", lat, 3);
        check("n1_ea", bus.effective_address, 32'h0000_0234);
        check("n1_pops", pops - p0, 1);
`endif

        // reset asserted mid-displacement
        @(posedge clk);
        #1;
        push(8'h86);
        push(8'h11);
        push(8'h22);
        bus.addr32 = 1'b0;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("r_busy", bus.busy, 0);
        check("r_complete", bus.complete, 0);
        check("r_rd_en", bus.fifo_rd_en, 0);
        check("r_ea", bus.effective_address, 0);
        check("r_fields", {bus.ss_default, bus.rm_is_reg, bus.regnum, bus.rm_regnum}, 0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        push(8'h00);
        p0 = pops;
        run(1'b0, 0, lat);
        check("r2_lat", lat, 3);
        check("r2_ea", bus.effective_address, 32'h0000_1234);
        check("r2_pops", pops - p0, 1);
        check("end_bad_pops", bad_pops, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
